jk_bank_arbiter: RTL and testbench

- Shares one bank of WIDTH JK flip-flops between N_REQ requesters.
- Each requester posts a command (hold / clear / set / toggle) with a bit mask.
- The block arbitrates round-robin, drives the bank's J/K inputs for exactly one clock edge, then reads Q back to verify the update.
- Sits between the requesters and the JK flip-flop bank. The bank's own async set/reset pins stay outside this block.

---
 rtl/jk_bank_arbiter.sv | 138 +++++++++++++
 tb/tb_jk_bank_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that lends one shared JK flip-flop bank to N_REQ requesters.
// Each transaction drives J/K for one edge and then checks the Q readback against the expected value.
module jk_bank_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     cmd,
  input  logic [WIDTH*N_REQ-1:0] mask,
  input  logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       j,
  output logic [WIDTH-1:0]       k,
  output logic [N_REQ-1:0]       gnt,
  output logic                   err,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic                   busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic [PTR_W-1:0]   id_l, id_d;
  logic [1:0]         cmd_l, cmd_d;
  logic [WIDTH-1:0]   mask_l, mask_d;
  logic [WIDTH-1:0]   exp_l, exp_d;
  logic [WIDTH-1:0]   j_d, k_d;
  logic [N_REQ-1:0]   gnt_d;
  logic               busy_d;

  logic               sel_vld;
  logic [PTR_W-1:0]   sel_id;
  logic [1:0]         sel_cmd;
  logic [WIDTH-1:0]   sel_mask;
  int                 idx;

  // Rotating priority scan; walking downward leaves the closest requester to ptr as the winner.
  always_comb begin
    sel_vld  = 1'b0;
    sel_id   = '0;
    sel_cmd  = '0;
    sel_mask = '0;
    idx      = 0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % int'(N_REQ);
      if (req[idx]) begin
        sel_vld  = 1'b1;
        sel_id   = PTR_W'(idx);
        sel_cmd  = cmd[2*idx +: 2];
        sel_mask = mask[int'(WIDTH)*idx +: WIDTH];
      end
    end
  end

  // Readback is only meaningful after the bank has taken its single update edge.
  assign err = (state == CHECK) && (q != exp_l);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    id_d    = id_l;
    cmd_d   = cmd_l;
    mask_d  = mask_l;
    exp_d   = exp_l;
    j_d     = '0;
    k_d     = '0;
    gnt_d   = '0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_d = DRIVE;
          id_d    = sel_id;
          cmd_d   = sel_cmd;
          mask_d  = sel_mask;
          j_d     = sel_mask & {WIDTH{sel_cmd[1]}};
          k_d     = sel_mask & {WIDTH{sel_cmd[0]}};
        end
      end
      DRIVE: begin
        state_d = CHECK;
        gnt_d   = N_REQ'(1) << id_l;
        case (cmd_l)
          2'b01:   exp_d = q & ~mask_l;
          2'b10:   exp_d = q | mask_l;
          2'b11:   exp_d = q ^ mask_l;
          default: exp_d = q;
        endcase
      end
      CHECK: begin
        state_d = IDLE;
        ptr_d   = (id_l == PTR_W'(N_REQ - 1)) ? '0 : id_l + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      id_l    <= '0;
      cmd_l   <= '0;
      mask_l  <= '0;
      exp_l   <= '0;
      j       <= '0;
      k       <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      err_cnt <= '0;
    end else begin
      ptr    <= ptr_d;
      id_l   <= id_d;
      cmd_l  <= cmd_d;
      mask_l <= mask_d;
      exp_l  <= exp_d;
      j      <= j_d;
      k      <= k_d;
      gnt    <= gnt_d;
      busy   <= busy_d;
      if (err && (err_cnt != {ERR_CNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter with a behavioural JK bank whose async set/reset can be forced.
module tb_jk_bank_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int unsigned E = 8;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [2*N-1:0]   cmd;
  logic [W*N-1:0]   mask;
  logic [W-1:0]     q;
  logic [W-1:0]     j;
  logic [W-1:0]     k;
  logic [N-1:0]     gnt;
  logic             err;
  logic [E-1:0]     err_cnt;
  logic             busy;

  logic             frc;
  logic [W-1:0]     frc_val;

  int n_chk;
  int n_err;

  logic [W-1:0] o_j, o_k, o_q;
  logic [N-1:0] o_gnt;
  logic         o_err, o_busy;

  jk_bank_arbiter #(.N_REQ(N), .WIDTH(W), .ERR_CNT_W(E)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .cmd     (cmd),
    .mask    (mask),
    .q       (q),
    .j       (j),
    .k       (k),
    .gnt     (gnt),
    .err     (err),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // JK bank: async force models the bank's own set/reset pins.
  always @(posedge clk or posedge frc) begin
    if (frc) q <= frc_val;
    else     q <= (j & ~q) | (~k & q);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // One transaction starting from an IDLE negedge; leaves the bench at the next IDLE negedge.
  task automatic run_txn(input int id, input logic [1:0] cv, input logic [W-1:0] mv, input bit frc_en);
    req = '0;
    req[id] = 1'b1;
    cmd[2*id +: 2] = cv;
    mask[W*id +: W] = mv;
    @(negedge clk);
    o_j = j;
    o_k = k;
    o_busy = busy;
    if (frc_en) begin
      frc_val = 8'hAA;
      frc = 1'b1;
    end
    @(negedge clk);
    o_gnt = gnt;
    o_err = err;
    o_q = q;
    req = '0;
    frc = 1'b0;
    @(negedge clk);
  endtask

  task automatic single(input string tag, input int id, input logic [1:0] cv, input logic [W-1:0] mv,
                        input logic [W-1:0] ej, input logic [W-1:0] ek, input logic [W-1:0] eq);
    run_txn(id, cv, mv, 1'b0);
    chk({tag, "_j"}, 32'(o_j), 32'(ej));
    chk({tag, "_k"}, 32'(o_k), 32'(ek));
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    chk({tag, "_gnt"}, 32'(o_gnt), 32'(1 << id));
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_q"}, 32'(o_q), 32'(eq));
  endtask

  task automatic run_rr(input string tag, input int e0, input int e1, input int e2, input int e3);
    int ord[4];
    int ngr, cyc, last, gid;
    ord[0] = e0; ord[1] = e1; ord[2] = e2; ord[3] = e3;
    ngr = 0; cyc = 0; last = 0;
    cmd = '0;
    mask = '0;
    req = 4'b1111;
    while (req != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt != 0) begin
        gid = 0;
        for (int b = N - 1; b >= 0; b--) if (gnt[b]) gid = b;
        if (ngr < 4) chk({tag, "_order"}, 32'(gid), 32'(ord[ngr]));
        if (ngr > 0) chk({tag, "_gap"}, 32'(cyc - last), 32'd3);
        last = cyc;
        ngr++;
        req = req & ~gnt;
      end
    end
    chk({tag, "_count"}, 32'(ngr), 32'd4);
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    int ntx, cyc, first, nerr_pulse;
    bit got3;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req = '0;
    cmd = '0;
    mask = '0;
    frc_val = '0;
    frc = 1'b1;
    repeat (2) @(negedge clk);
    frc = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_k", 32'(k), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    single("set",    0, 2'b10, 8'h0F, 8'h0F, 8'h00, 8'h0F);
    single("toggle", 0, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'hF0);
    single("clear",  0, 2'b01, 8'hF0, 8'h00, 8'hF0, 8'h00);
    single("hold",   0, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00);

    single("ptr0", 3, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_rr("rr0", 0, 1, 2, 3);
    single("ptr2", 1, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_rr("rr2", 2, 3, 0, 1);

    // Fairness: requester 0 never drops, requester 3 waits.
    single("ptrf", 3, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    cmd = '0;
    mask = '0;
    req = 4'b1001;
    ntx = 0; cyc = 0; first = 0; got3 = 1'b0;
    while (!got3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt != 0) begin
        ntx++;
        if (ntx == 1) first = int'(gnt);
        if (gnt[3]) begin
          got3 = 1'b1;
          req = '0;
        end
      end
    end
    chk("fair_first", 32'(first), 32'h1);
    chk("fair_tx", 32'(ntx), 32'd2);
    req = '0;
    @(negedge clk);

    // Mismatch: bank held at AA through the DRIVE edge of a set-bit0.
    run_txn(0, 2'b10, 8'h01, 1'b1);
    chk("mis_gnt", 32'(o_gnt), 32'h1);
    chk("mis_err", 32'(o_err), 32'd1);
    chk("mis_q", 32'(o_q), 32'hAA);
    chk("mis_cnt1", 32'(err_cnt), 32'd1);
    nerr_pulse = 0;
    for (int n = 0; n < 299; n++) begin
      run_txn(0, 2'b10, 8'h01, 1'b1);
      if (o_err && o_gnt == 4'b0001) nerr_pulse++;
    end
    chk("mis_pulses", 32'(nerr_pulse), 32'd299);
    chk("mis_sat", 32'(err_cnt), 32'd255);

    // Async reset in the middle of DRIVE.
    req = 4'b0100;
    cmd[5:4] = 2'b10;
    mask[23:16] = 8'h10;
    @(negedge clk);
    chk("ar_drive_j", 32'(j), 32'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_j", 32'(j), 32'd0);
    chk("ar_k", 32'(k), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_cnt", 32'(err_cnt), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_nognt", 32'(gnt), 32'd0);
    chk("ar_redrive_j", 32'(j), 32'h10);
    chk("ar_redrive_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ar_gnt", 32'(gnt), 32'b0100);
    chk("ar_err", 32'(err), 32'd0);
    chk("ar_q", 32'(q), 32'hBA);
    req = '0;
    @(negedge clk);
    chk("ar_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
